// File: rtl/s4_bridge_buffer.sv
// s4_bridge_buffer: channel-major staging buffer between the serialized
// layer-2 engine and the C5 fully-connected stage. Each layer-2 channel pass
// is captured at address ch*PIX_PER_CH + p. Once every channel is marked,
// the whole map is streamed to C5 one word per cycle with no gaps.
// Optional build macro: S4_BRIDGE_ERRCHK_EN enables the sticky err[1:0] checks.
module s4_bridge_buffer #(
  parameter int CHANNELS   = 16,
  parameter int PIX_PER_CH = 25,
  parameter int DATA_W     = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                ch_start,
  input  logic [3:0]          ch_id,
  input  logic                in_valid,
  input  logic [DATA_W-1:0]   in_pixel,
  input  logic                ch_done,
  output logic                out_valid,
  output logic [DATA_W-1:0]   out_pixel,
  output logic                out_last,
  output logic                send_done,
  output logic                busy,
  output logic [CHANNELS-1:0] ch_captured,
  output logic [1:0]          err
);

  localparam int TOTAL  = CHANNELS * PIX_PER_CH;
  localparam int ADDR_W = $clog2(TOTAL);
  localparam int CNT_W  = $clog2(PIX_PER_CH + 1);

  localparam logic [ADDR_W-1:0] LAST_ADDR = ADDR_W'(TOTAL - 1);
  localparam logic [CNT_W-1:0]  CNT_FULL  = CNT_W'(PIX_PER_CH);
  localparam logic [4:0]        CH_LIM    = 5'(CHANNELS);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_CAPTURE,
    ST_SEND,
    ST_FINISH
  } state_t;

  state_t              r_state;
  logic [DATA_W-1:0]   r_mem [0:TOTAL-1];
  logic [3:0]          r_cur_ch;
  logic [ADDR_W-1:0]   r_wr_base;
  logic [CNT_W-1:0]    r_wr_cnt;
  logic [ADDR_W-1:0]   r_rd_ptr;
  logic                r_out_valid;
  logic [DATA_W-1:0]   r_out_pixel;
  logic                r_out_last;
  logic                r_send_done;
  logic                r_busy;
  logic [CHANNELS-1:0] r_ch_captured;

  logic                w_id_ok;
  logic                w_in_cap;
  logic                w_restart;
  logic                w_wr_en;
  logic                w_done;
  logic [ADDR_W-1:0]   w_wr_addr;
  logic [ADDR_W-1:0]   w_new_base;
  logic [CHANNELS-1:0] w_mask_next;

  // Out-of-range channel ids never start a capture.
  assign w_id_ok    = ({1'b0, ch_id} < CH_LIM);
  assign w_in_cap   = (r_state == ST_CAPTURE);
  // A valid ch_start (re)starts capture from IDLE or CAPTURE; it takes
  // priority over any pixel or ch_done in the same cycle.
  assign w_restart  = ch_start && w_id_ok &&
                      ((r_state == ST_IDLE) || (r_state == ST_CAPTURE));
  assign w_wr_en    = w_in_cap && !w_restart && in_valid && (r_wr_cnt != CNT_FULL);
  assign w_done     = w_in_cap && !w_restart && ch_done;
  assign w_wr_addr  = r_wr_base + ADDR_W'(r_wr_cnt);
  assign w_new_base = ADDR_W'(ch_id) * ADDR_W'(PIX_PER_CH);
  assign w_mask_next = r_ch_captured | (CHANNELS'(1) << r_cur_ch);

  // Pixel storage; contents are deliberately left untouched by rst.
  always_ff @(posedge clk) begin
    if (w_wr_en) begin
      r_mem[w_wr_addr] <= in_pixel;
    end
  end

  // Control FSM with registered stream outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_state       <= ST_IDLE;
      r_cur_ch      <= '0;
      r_wr_base     <= '0;
      r_wr_cnt      <= '0;
      r_rd_ptr      <= '0;
      r_out_valid   <= 1'b0;
      r_out_pixel   <= '0;
      r_out_last    <= 1'b0;
      r_send_done   <= 1'b0;
      r_busy        <= 1'b0;
      r_ch_captured <= '0;
    end else begin
      r_send_done <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (w_restart) begin
            r_cur_ch  <= ch_id;
            r_wr_base <= w_new_base;
            r_wr_cnt  <= '0;
            r_busy    <= 1'b1;
            r_state   <= ST_CAPTURE;
          end
        end
        ST_CAPTURE: begin
          if (w_restart) begin
            r_cur_ch  <= ch_id;
            r_wr_base <= w_new_base;
            r_wr_cnt  <= '0;
          end else begin
            if (w_wr_en) begin
              r_wr_cnt <= r_wr_cnt + 1'b1;
            end
            if (w_done) begin
              r_ch_captured <= w_mask_next;
              if (&w_mask_next) begin
                r_rd_ptr <= '0;
                r_state  <= ST_SEND;
              end else begin
                r_busy  <= 1'b0;
                r_state <= ST_IDLE;
              end
            end
          end
        end
        ST_SEND: begin
          r_out_valid <= 1'b1;
          r_out_pixel <= r_mem[r_rd_ptr];
          r_out_last  <= (r_rd_ptr == LAST_ADDR);
          if (r_rd_ptr == LAST_ADDR) begin
            r_state <= ST_FINISH;
          end else begin
            r_rd_ptr <= r_rd_ptr + 1'b1;
          end
        end
        ST_FINISH: begin
          r_out_valid   <= 1'b0;
          r_out_last    <= 1'b0;
          r_send_done   <= 1'b1;
          r_ch_captured <= '0;
          r_busy        <= 1'b0;
          r_state       <= ST_IDLE;
        end
        default: begin
          r_busy  <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign out_valid   = r_out_valid;
  assign out_pixel   = r_out_pixel;
  assign out_last    = r_out_last;
  assign send_done   = r_send_done;
  assign busy        = r_busy;
  assign ch_captured = r_ch_captured;

`ifdef S4_BRIDGE_ERRCHK_EN
  logic [1:0]       r_err;
  logic [CNT_W-1:0] w_cnt_eff;
  logic             w_drop;
  logic             w_short;
  logic             w_proto;

  // The count check sees the pixel written in the same cycle as ch_done.
  assign w_cnt_eff = r_wr_cnt + CNT_W'(w_wr_en);
  assign w_drop    = w_in_cap && !w_restart && in_valid && (r_wr_cnt == CNT_FULL);
  assign w_short   = w_done && (w_cnt_eff != CNT_FULL);
  assign w_proto   = ch_start &&
                     (!w_id_ok || (r_state == ST_CAPTURE) || (r_state == ST_SEND));

  // Sticky error flags, cleared only by rst.
  always_ff @(posedge clk) begin
    if (rst) begin
      r_err <= '0;
    end else begin
      if (w_short || w_drop) begin
        r_err[0] <= 1'b1;
      end
      if (w_proto) begin
        r_err[1] <= 1'b1;
      end
    end
  end

  assign err = r_err;
`else
  assign err = 2'b00;
`endif

endmodule

// File: tb/tb_s4_bridge_buffer.sv
// Directed bench for s4_bridge_buffer: capture/stream runs in several orders,
// gapped input, error scenario, and reset in the middle of a stream.
module tb_s4_bridge_buffer;

`ifdef S4_BRIDGE_ERRCHK_EN
  localparam bit ERRCHK = 1'b1;
`else
  localparam bit ERRCHK = 1'b0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic        ch_start;
  logic [3:0]  ch_id;
  logic        in_valid;
  logic [7:0]  in_pixel;
  logic        ch_done;
  logic        out_valid;
  logic [7:0]  out_pixel;
  logic        out_last;
  logic        send_done;
  logic        busy;
  logic [15:0] ch_captured;
  logic [1:0]  err;

  int n_assert = 0;
  int n_fail   = 0;
  logic [7:0]  exp_mem [400];
  logic [15:0] exp_mask;

  s4_bridge_buffer #(
    .CHANNELS  (16),
    .PIX_PER_CH(25),
    .DATA_W    (8)
  ) dut (
    .clk        (clk),
    .rst        (rst),
    .ch_start   (ch_start),
    .ch_id      (ch_id),
    .in_valid   (in_valid),
    .in_pixel   (in_pixel),
    .ch_done    (ch_done),
    .out_valid  (out_valid),
    .out_pixel  (out_pixel),
    .out_last   (out_last),
    .send_done  (send_done),
    .busy       (busy),
    .ch_captured(ch_captured),
    .err        (err)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [7:0] pat(input int c, input int p, input int mul, input int add);
    return 8'((c * 25 + p) * mul + add);
  endfunction

  // Start channel c, feed n pixels, then ch_done (optionally overlapped with
  // the final pixel). Only the first 25 pixels land in the model.
  task automatic send_channel(input int c, input int n, input bit gaps,
                              input bit overlap, input int mul, input int add);
    ch_start = 1'b1;
    ch_id    = 4'(c);
    tick();
    ch_start = 1'b0;
    for (int p = 0; p < n; p++) begin
      if (gaps && p > 0) begin
        in_valid = 1'b0;
        tick();
      end
      in_valid = 1'b1;
      in_pixel = pat(c, p, mul, add);
      if (p < 25) exp_mem[c * 25 + p] = pat(c, p, mul, add);
      if (overlap && p == n - 1) ch_done = 1'b1;
      tick();
    end
    in_valid = 1'b0;
    if (!overlap) begin
      ch_done = 1'b1;
      tick();
    end
    ch_done = 1'b0;
  endtask

  // Entered at T+1 (just after the edge that took the completing ch_done).
  task automatic check_stream(input logic [1:0] exp_err);
    chk("busy_at_T1", busy, 1'b1);
    chk("valid_at_T1", out_valid, 1'b0);
    for (int k = 0; k < 400; k++) begin
      tick();
      chk($sformatf("stream[%0d]", k), {out_valid, out_pixel, out_last},
          {1'b1, exp_mem[k], (k == 399)});
    end
    tick();
    chk("done_pulse", {out_valid, send_done}, 2'b01);
    chk("err_end", err, exp_err);
    tick();
    chk("after_done", {send_done, busy}, 2'b00);
    chk("mask_cleared", ch_captured, 16'h0000);
  endtask

  task automatic run_all(input bit rev, input int mul, input int add,
                         input int gap_ch, input bit do_stream, input logic [1:0] exp_err);
    int c;
    exp_mask = '0;
    for (int i = 0; i < 16; i++) begin
      c = rev ? 15 - i : i;
      send_channel(c, 25, (c == gap_ch), (c == gap_ch), mul, add);
      exp_mask[c] = 1'b1;
      if (i < 15) begin
        chk($sformatf("mask_ch%0d", c), ch_captured, exp_mask);
        chk($sformatf("idle_ch%0d", c), {busy, out_valid}, 2'b00);
      end
    end
    if (do_stream) check_stream(exp_err);
  endtask

  initial begin
    logic seen_done;
    rst = 1'b1; ch_start = 1'b0; ch_id = '0; in_valid = 1'b0;
    in_pixel = '0; ch_done = 1'b0;
    tick();
    tick();
    chk("reset_outs", {out_valid, out_pixel, out_last, send_done, busy},
        {1'b0, 8'h00, 1'b0, 1'b0, 1'b0});
    chk("reset_mask", ch_captured, 16'h0000);
    chk("reset_err", err, 2'b00);
    rst = 1'b0;
    tick();

    // IDLE ignores in_valid and ch_done.
    in_valid = 1'b1; in_pixel = 8'h5A; ch_done = 1'b1;
    tick();
    in_valid = 1'b0; ch_done = 1'b0;
    tick();
    chk("idle_ignore", {busy, ch_captured}, 17'h0);

    // Nominal in-order run: word k carries k mod 256.
    run_all(1'b0, 1, 0, -1, 1'b1, 2'b00);
    // Reverse order gives the same stream.
    run_all(1'b1, 1, 0, -1, 1'b1, 2'b00);
    // Gapped input on channel 7 with last pixel overlapping ch_done.
    run_all(1'b0, 3, 5, 7, 1'b1, 2'b00);

    // Error scenario: restart ch5 mid-capture, short ch3, long ch4.
    ch_start = 1'b1; ch_id = 4'd5;
    tick();
    ch_start = 1'b0;
    for (int p = 0; p < 3; p++) begin
      in_valid = 1'b1; in_pixel = 8'hEE;
      tick();
    end
    in_valid = 1'b0;
    chk("err_none_yet", err, 2'b00);
    send_channel(5, 25, 1'b0, 1'b0, 5, 11);
    chk("err_proto", err, ERRCHK ? 2'b10 : 2'b00);
    send_channel(3, 24, 1'b0, 1'b0, 5, 11);
    chk("err_short", err, ERRCHK ? 2'b11 : 2'b00);
    send_channel(4, 26, 1'b0, 1'b0, 5, 11);
    chk("mask_err_run", ch_captured, 16'h0038);
    exp_mask = 16'h0038;
    for (int c = 0; c < 16; c++) begin
      if (c < 3 || c > 5) begin
        send_channel(c, 25, 1'b0, 1'b0, 5, 11);
        exp_mask[c] = 1'b1;
      end
    end
    // Word 99 keeps the previous run's value; word 125 holds ch5 p0, not ch4's 26th.
    check_stream(ERRCHK ? 2'b11 : 2'b00);

    // Reset in the middle of a stream.
    run_all(1'b0, 7, 1, -1, 1'b0, 2'b00);
    for (int k = 0; k <= 100; k++) begin
      tick();
      chk($sformatf("pre_rst[%0d]", k), {out_valid, out_pixel}, {1'b1, exp_mem[k]});
    end
    rst = 1'b1;
    tick();
    rst = 1'b0;
    chk("rst_abort_valid", out_valid, 1'b0);
    chk("rst_abort_mask", ch_captured, 16'h0000);
    chk("rst_abort_busy_err", {busy, err}, 3'b000);
    seen_done = 1'b0;
    for (int k = 0; k < 8; k++) begin
      tick();
      seen_done = seen_done | send_done | out_valid;
    end
    chk("no_done_after_rst", seen_done, 1'b0);

    // Fresh run after the abort.
    run_all(1'b0, 1, 0, -1, 1'b1, 2'b00);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end

endmodule
